battery_status_monitor: RTL and testbench

- Parametrised successor to the single-shot battery status block.
- On a start request it sequentially samples NUM_CELLS battery cell voltages through a req/ack ADC interface.
- Per run it computes sum, minimum (with index), maximum and a per-cell low-voltage mask, with per-sample timeout and a one-cycle done pulse.
- Sits between the power-management controller (start/done) and the shared ADC arbiter (req/ack).

---
 rtl/battery_status_monitor.sv | 177 +++++++++++++++++
 tb/tb_battery_status_monitor.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battery_status_monitor.sv
// Sequential NUM_CELLS battery-cell sampler over a req/ack ADC port: sum, min (with index), max and low-voltage mask per run.
// Optional low-mask hysteresis is enabled by defining BATTMON_HYST_EN.
module battery_status_monitor #(
    parameter int  NUM_CELLS      = 4,
    parameter int  SAMPLE_W       = 12,
    parameter int  LOW_THRESH     = 3000,
    parameter int  HYST           = 100,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int CH_W           = $clog2(NUM_CELLS),
    localparam int SUM_W          = SAMPLE_W + CH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 adc_req,
    output logic [CH_W-1:0]      adc_ch,
    input  logic                 adc_ack,
    input  logic [SAMPLE_W-1:0]  adc_data,
    output logic [SUM_W-1:0]     sum_out,
    output logic [SAMPLE_W-1:0]  min_out,
    output logic [CH_W-1:0]      min_idx,
    output logic [SAMPLE_W-1:0]  max_out,
    output logic [NUM_CELLS-1:0] low_mask
);

`ifdef BATTMON_HYST_EN
    localparam logic HYST_EN = 1'b1;
`else
    localparam logic HYST_EN = 1'b0;
`endif

    // The counter holds the number of ack-less REQ cycles already spent; it fires on the last allowed one.
    localparam int                TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CH_W-1:0]   LAST_IDX = CH_W'(NUM_CELLS - 1);
    localparam logic [SAMPLE_W:0] LOW_SET  = (SAMPLE_W + 1)'(LOW_THRESH);
    localparam logic [SAMPLE_W:0] LOW_CLR  = LOW_SET + (SAMPLE_W + 1)'(HYST);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [TO_W-1:0]       to_cnt;
    logic [SUM_W-1:0]      sum_acc;
    logic [SAMPLE_W-1:0]   min_acc;
    logic [CH_W-1:0]       min_idx_acc;
    logic [SAMPLE_W-1:0]   max_acc;
    logic [NUM_CELLS-1:0]  low_acc;

    logic                  accept;
    logic                  capture;
    logic                  last_cell;
    logic                  timeout_hit;
    logic                  below;
    logic                  above;
    logic                  low_new;
    logic [SUM_W-1:0]      sum_upd;
    logic [SAMPLE_W-1:0]   min_upd;
    logic [CH_W-1:0]       min_idx_upd;
    logic [SAMPLE_W-1:0]   max_upd;
    logic [NUM_CELLS-1:0]  low_upd;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (capture) begin
                    state_next = last_cell ? IDLE : GAP;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            GAP:     state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = (state == IDLE) && start;
        capture     = (state == REQ) && adc_ack;
        last_cell   = (adc_ch == LAST_IDX);
        timeout_hit = (state == REQ) && !adc_ack && TO_EN && (to_cnt == TO_LAST);

        // Inside the hysteresis band a cell keeps its last published low bit.
        below   = ({1'b0, adc_data} < LOW_SET);
        above   = ({1'b0, adc_data} >= LOW_CLR);
        low_new = below | (HYST_EN & ~above & low_mask[adc_ch]);

        sum_upd     = sum_acc + SUM_W'(adc_data);
        min_upd     = min_acc;
        min_idx_upd = min_idx_acc;
        if (adc_data < min_acc) begin
            min_upd     = adc_data;
            min_idx_upd = adc_ch;
        end
        max_upd         = (adc_data > max_acc) ? adc_data : max_acc;
        low_upd         = low_acc;
        low_upd[adc_ch] = low_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            adc_req     <= 1'b0;
            adc_ch      <= '0;
            to_cnt      <= '0;
            sum_acc     <= '0;
            min_acc     <= '0;
            min_idx_acc <= '0;
            max_acc     <= '0;
            low_acc     <= '0;
            sum_out     <= '0;
            min_out     <= '0;
            min_idx     <= '0;
            max_out     <= '0;
            low_mask    <= '0;
        end else begin
            busy    <= (state_next != IDLE);
            adc_req <= (state_next == REQ);
            done    <= 1'b0;
            to_cnt  <= ((state == REQ) && !adc_ack && !timeout_hit) ? to_cnt + TO_W'(1) : '0;

            if (accept) begin
                err         <= 1'b0;
                adc_ch      <= '0;
                sum_acc     <= '0;
                min_acc     <= '1;
                min_idx_acc <= '0;
                max_acc     <= '0;
                low_acc     <= '0;
            end

            if (capture) begin
                sum_acc     <= sum_upd;
                min_acc     <= min_upd;
                min_idx_acc <= min_idx_upd;
                max_acc     <= max_upd;
                low_acc     <= low_upd;
                if (last_cell) begin
                    done     <= 1'b1;
                    sum_out  <= sum_upd;
                    min_out  <= min_upd;
                    min_idx  <= min_idx_upd;
                    max_out  <= max_upd;
                    low_mask <= low_upd;
                end else begin
                    adc_ch <= adc_ch + CH_W'(1);
                end
            end else if (timeout_hit) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_battery_status_monitor.sv
// Scoreboard bench for battery_status_monitor: a behavioural ADC responder feeds samples,
// expected run results are queued at start and compared on every done pulse.
module tb_battery_status_monitor;

    localparam int NUM_CELLS  = 4;
    localparam int SAMPLE_W   = 12;
    localparam int LOW_THRESH = 3000;
    localparam int HYST       = 100;
    localparam int CH_W       = 2;
    localparam int SUM_W      = 14;

`ifdef BATTMON_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 adc_req;
    logic [CH_W-1:0]      adc_ch;
    logic                 adc_ack;
    logic [SAMPLE_W-1:0]  adc_data;
    logic [SUM_W-1:0]     sum_out;
    logic [SAMPLE_W-1:0]  min_out;
    logic [CH_W-1:0]      min_idx;
    logic [SAMPLE_W-1:0]  max_out;
    logic [NUM_CELLS-1:0] low_mask;

    battery_status_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .adc_req  (adc_req),
        .adc_ch   (adc_ch),
        .adc_ack  (adc_ack),
        .adc_data (adc_data),
        .sum_out  (sum_out),
        .min_out  (min_out),
        .min_idx  (min_idx),
        .max_out  (max_out),
        .low_mask (low_mask)
    );

    typedef struct {
        int sum;
        int mn;
        int mi;
        int mx;
        int mask;
        int err;
    } exp_t;

    exp_t sb[$];
    exp_t last_good;
    exp_t mon_e;

    int samples[NUM_CELLS];
    int ack_delay = 0;
    int withhold  = -1;
    bit glitch_en = 1'b0;
    int wait_cnt  = 0;
    int checks    = 0;
    int errors    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_samples(input int a, input int b, input int c, input int d);
        samples[0] = a;
        samples[1] = b;
        samples[2] = c;
        samples[3] = d;
    endtask

    // Reference model: what the published outputs must be when this run's done pulse arrives.
    task automatic push_expected(input bit will_timeout);
        exp_t e;
        if (will_timeout) begin
            e     = last_good;
            e.err = 1;
        end else begin
            e.sum  = 0;
            e.mn   = (1 << SAMPLE_W) - 1;
            e.mi   = 0;
            e.mx   = 0;
            e.mask = 0;
            e.err  = 0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                e.sum += samples[i];
                if (samples[i] < e.mn) begin
                    e.mn = samples[i];
                    e.mi = i;
                end
                if (samples[i] > e.mx) e.mx = samples[i];
                if (samples[i] < LOW_THRESH) e.mask |= (1 << i);
                else if (HYST_EN && samples[i] < LOW_THRESH + HYST) e.mask |= last_good.mask & (1 << i);
            end
            last_good = e;
        end
        sb.push_back(e);
    endtask

    // ADC responder: acks after ack_delay REQ cycles, never acks the withheld cell,
    // and optionally drives junk acks whenever adc_req is low.
    initial begin
        adc_ack  = 1'b0;
        adc_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (adc_req === 1'b1 && int'(adc_ch) != withhold) begin
                if (wait_cnt >= ack_delay) begin
                    adc_ack  = 1'b1;
                    adc_data = SAMPLE_W'(samples[adc_ch]);
                end else begin
                    adc_ack = 1'b0;
                    wait_cnt++;
                end
            end else if (adc_req !== 1'b1 && glitch_en) begin
                adc_ack  = 1'b1;
                adc_data = SAMPLE_W'(1);
                wait_cnt = 0;
            end else begin
                adc_ack  = 1'b0;
                wait_cnt = (adc_req === 1'b1) ? wait_cnt : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sum_out", sum_out, mon_e.sum);
                check("min_out", min_out, mon_e.mn);
                check("min_idx", min_idx, mon_e.mi);
                check("max_out", max_out, mon_e.mx);
                check("low_mask", low_mask, mon_e.mask);
                check("err", err, mon_e.err);
            end
        end
    end

    // Called #1 after a clock edge with the DUT idle; returns one cycle after done.
    task automatic run(input bit will_timeout, input int exp_lat, input bit poke_start);
        int   n;
        logic req_before;
        push_expected(will_timeout);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_err", err, 0);
        n          = 1;
        req_before = 1'b0;
        while (done !== 1'b1 && n < 2000) begin
            start      = poke_start && (n == 3);
            req_before = adc_req;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, exp_lat);
        if (will_timeout) begin
            check("req_before_timeout", req_before, 1);
            check("req_after_timeout", adc_req, 0);
        end
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
    endtask

    initial begin
        int n;
        int saw;
        int hv[3];
        int h_exp[3];
        hv = '{2900, 3050, 3100};
`ifdef BATTMON_HYST_EN
        h_exp = '{1, 1, 0};
`else
        h_exp = '{1, 0, 0};
`endif
        last_good = '{0, 0, 0, 0, 0, 0};
        set_samples(0, 0, 0, 0);

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req", adc_req, 0);
        check("rst_ch", adc_ch, 0);
        check("rst_sum", sum_out, 0);
        check("rst_min", min_out, 0);
        check("rst_min_idx", min_idx, 0);
        check("rst_max", max_out, 0);
        check("rst_mask", low_mask, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reference run with a min tie on cells 1 and 3.
        set_samples(3500, 2900, 3100, 2900);
        run(1'b0, 8, 1'b0);
        check("a_sum", sum_out, 12400);
        check("a_min", min_out, 2900);
        check("a_min_idx", min_idx, 1);
        check("a_max", max_out, 3500);
        check("a_mask", low_mask, 4'b1010);
        check("a_err", err, 0);

        // Junk acks outside REQ and a start pulse while busy must change nothing.
        set_samples(200, 4000, 50, 4000);
        glitch_en = 1'b1;
        run(1'b0, 8, 1'b1);
        glitch_en = 1'b0;
        check("b_idle", busy, 0);

        // Threshold boundary and full-scale samples with slow acks.
        set_samples(3000, 2999, 4095, 3001);
        ack_delay = 2;
        run(1'b0, 16, 1'b0);
        ack_delay = 0;

        // Timeout on cell 2.
        set_samples(1000, 1000, 1000, 1000);
        withhold = 2;
        run(1'b1, 260, 1'b0);
        withhold = -1;
        check("err_held", err, 1);

        set_samples(2500, 3600, 2999, 3000);
        run(1'b0, 8, 1'b0);

        // Back-to-back: start held across the first done.
        set_samples(3100, 2800, 3300, 2950);
        push_expected(1'b0);
        push_expected(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_lat1", n, 8);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_req", adc_req, 1);
        check("b2b_ch", adc_ch, 0);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_lat2", n, 8);
        @(posedge clk);
        #1;

        // Reset during REQ of cell 1.
        set_samples(1234, 2345, 3456, 4000);
        push_expected(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(adc_req === 1'b1 && adc_ch === 2'd1) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_cell1", (n < 50), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        last_good = '{0, 0, 0, 0, 0, 0};
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", adc_req, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum_out, 0);
        check("mid_rst_min", min_out, 0);
        check("mid_rst_max", max_out, 0);
        check("mid_rst_mask", low_mask, 0);
        saw = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || adc_req !== 1'b0) saw = 1;
        end
        check("quiet_after_rst", saw, 0);

        // Cell 0 walks through the hysteresis band.
        for (int k = 0; k < 3; k++) begin
            set_samples(hv[k], 3500, 3500, 3500);
            run(1'b0, 8, 1'b0);
            check("hyst_cell0", low_mask[0], h_exp[k]);
        end

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
